// File: rtl/stereo_gray_pkg.sv
// stereo_gray_pkg: conversion modes, RGB component ordering and luma coefficient helper
package stereo_gray_pkg;
  typedef enum logic [1:0] {
    GRAY_YUV422 = 2'd0,
    GRAY_RGB    = 2'd1,
    GRAY_CH_SEL = 2'd2
  } gray_mode_t;
  localparam int RGB_G_IDX = 0;
  localparam int RGB_B_IDX = 1;
  localparam int RGB_R_IDX = 2;
  // G absorbs the rounding error of R and B so the weights always sum to 2**coef_w
  function automatic int gray_coef(input int coef_w, input int idx);
    int r;
    int b;
    r = (299 * (1 << coef_w) + 500) / 1000;
    b = (114 * (1 << coef_w) + 500) / 1000;
    return idx == RGB_R_IDX ? r : idx == RGB_B_IDX ? b : (1 << coef_w) - r - b;
  endfunction
endpackage

// File: rtl/gray_px_luma.sv
// gray_px_luma: one pixel of the two-stage luma pipeline (S1 weighted products, S2 sum/shift)
// PIXEL_TO_GRAY_ROUND_EN selects round-half-up instead of truncation in S2
module gray_px_luma
  import stereo_gray_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_W     = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s1_en_i,
  input  logic                  s2_en_i,
  input  gray_mode_t            mode_i,
  input  logic [DATA_WIDTH-1:0] r_i,
  input  logic [DATA_WIDTH-1:0] g_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] sel_i,
  output logic [DATA_WIDTH-1:0] gray_o
);
  localparam int PW = DATA_WIDTH + COEF_W;
  localparam int SW = PW + 1;
  localparam logic [PW-1:0] CR = PW'(gray_coef(COEF_W, RGB_R_IDX));
  localparam logic [PW-1:0] CG = PW'(gray_coef(COEF_W, RGB_G_IDX));
  localparam logic [PW-1:0] CB = PW'(gray_coef(COEF_W, RGB_B_IDX));
`ifdef PIXEL_TO_GRAY_ROUND_EN
  localparam logic [SW-1:0] RND = SW'(1) << (COEF_W - 1);
`else
  localparam logic [SW-1:0] RND = '0;
`endif
  logic [PW-1:0] pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
  logic [DATA_WIDTH-1:0] gray_q, gray_d;
  // non-RGB modes pre-scale the component so S2 is mode-independent
  always_comb begin
    pr_d   = mode_i == GRAY_RGB ? PW'(r_i) * CR : PW'(sel_i) << COEF_W;
    pg_d   = mode_i == GRAY_RGB ? PW'(g_i) * CG : '0;
    pb_d   = mode_i == GRAY_RGB ? PW'(b_i) * CB : '0;
    gray_d = DATA_WIDTH'((SW'(pr_q) + SW'(pg_q) + SW'(pb_q) + RND) >> COEF_W);
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      {pr_q, pg_q, pb_q, gray_q} <= '0;
    end else begin
      if (s1_en_i) {pr_q, pg_q, pb_q} <= {pr_d, pg_d, pb_d};
      if (s2_en_i) gray_q <= gray_d;
    end
  end
  assign gray_o = gray_q;
endmodule

// File: rtl/pixel_to_gray_conv.sv
// pixel_to_gray_conv: PPC-wide YUV422/RGB/channel-select to grayscale AXI4-Stream elastic pipeline
// PIXEL_TO_GRAY_ROUND_EN enables rounding of the RGB luma sum (truncation otherwise)
module pixel_to_gray_conv
  import stereo_gray_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PPC        = 4,
  parameter int COEF_W     = 8
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [1:0]                mode_i,
  input  logic [DATA_WIDTH*PPC*3-1:0] s_axis_pix_tdata,
  input  logic                      s_axis_pix_tuser,
  input  logic                      s_axis_pix_tlast,
  input  logic                      s_axis_pix_tvalid,
  output logic                      s_axis_pix_tready,
  output logic [DATA_WIDTH*PPC-1:0] m_axis_gray_tdata,
  output logic                      m_axis_gray_tuser,
  output logic                      m_axis_gray_tlast,
  output logic                      m_axis_gray_tvalid,
  input  logic                      m_axis_gray_tready,
  output logic [1:0]                frame_mode_o
);
  gray_mode_t frame_mode_q, frame_mode_d, beat_mode;
  logic s1_valid_q, s1_valid_d, s1_user_q, s1_user_d, s1_last_q, s1_last_d;
  logic s2_valid_q, s2_valid_d, s2_user_q, s2_user_d, s2_last_q, s2_last_d;
  logic s1_load, s2_load, s2_en, accept;
  always_comb begin
    s2_load           = !s2_valid_q || m_axis_gray_tready;
    s1_load           = !s1_valid_q || s2_load;
    s_axis_pix_tready = !areset && s1_load;
    accept            = s_axis_pix_tvalid && s_axis_pix_tready;
    s2_en             = s2_load && s1_valid_q;
    beat_mode         = accept && s_axis_pix_tuser
                        ? (mode_i == 2'd3 ? GRAY_YUV422 : gray_mode_t'(mode_i)) : frame_mode_q;
    frame_mode_d      = beat_mode;
    s1_valid_d        = s1_load ? accept : s1_valid_q;
    s1_user_d         = accept ? s_axis_pix_tuser : s1_user_q;
    s1_last_d         = accept ? s_axis_pix_tlast : s1_last_q;
    s2_valid_d        = s2_load ? s1_valid_q : s2_valid_q;
    s2_user_d         = s2_en ? s1_user_q : s2_user_q;
    s2_last_d         = s2_en ? s1_last_q : s2_last_q;
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      frame_mode_q <= GRAY_YUV422;
      {s1_valid_q, s1_user_q, s1_last_q, s2_valid_q, s2_user_q, s2_last_q} <= '0;
    end else begin
      frame_mode_q <= frame_mode_d;
      {s1_valid_q, s1_user_q, s1_last_q} <= {s1_valid_d, s1_user_d, s1_last_d};
      {s2_valid_q, s2_user_q, s2_last_q} <= {s2_valid_d, s2_user_d, s2_last_d};
    end
  end
  for (genvar p = 0; p < PPC; p++) begin : g_px
    logic [DATA_WIDTH-1:0] y, c0;
    assign y  = s_axis_pix_tdata[(2*p+1)*DATA_WIDTH +: DATA_WIDTH];
    assign c0 = s_axis_pix_tdata[3*p*DATA_WIDTH +: DATA_WIDTH];
    gray_px_luma #(.DATA_WIDTH(DATA_WIDTH), .COEF_W(COEF_W)) u_luma (
      .aclk    (aclk),
      .areset  (areset),
      .s1_en_i (accept),
      .s2_en_i (s2_en),
      .mode_i  (beat_mode),
      .r_i     (s_axis_pix_tdata[(3*p+RGB_R_IDX)*DATA_WIDTH +: DATA_WIDTH]),
      .g_i     (s_axis_pix_tdata[(3*p+RGB_G_IDX)*DATA_WIDTH +: DATA_WIDTH]),
      .b_i     (s_axis_pix_tdata[(3*p+RGB_B_IDX)*DATA_WIDTH +: DATA_WIDTH]),
      .sel_i   (beat_mode == GRAY_YUV422 ? y : c0),
      .gray_o  (m_axis_gray_tdata[p*DATA_WIDTH +: DATA_WIDTH])
    );
  end
  assign m_axis_gray_tvalid = s2_valid_q;
  assign m_axis_gray_tuser  = s2_user_q;
  assign m_axis_gray_tlast  = s2_last_q;
  assign frame_mode_o       = frame_mode_q;
endmodule

// File: tb/tb_pixel_to_gray_conv.sv
// tb_pixel_to_gray_conv: scoreboard bench for pixel_to_gray_conv (DATA_WIDTH=8, PPC=4, COEF_W=8)
module tb_pixel_to_gray_conv;
  typedef struct packed {logic [31:0] d; logic u; logic l;} exp_t;
  logic aclk = 0, areset;
  logic [1:0] mode_i, frame_mode;
  logic [95:0] s_tdata;
  logic s_tuser, s_tlast, s_tvalid, s_tready;
  logic [31:0] m_tdata;
  logic m_tuser, m_tlast, m_tvalid, m_tready;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [1:0] mdl_mode;
`ifdef PIXEL_TO_GRAY_ROUND_EN
  localparam int RND = 128;
  localparam logic [7:0] RED_GRAY = 8'd77;
`else
  localparam int RND = 0;
  localparam logic [7:0] RED_GRAY = 8'd76;
`endif
  always #5 aclk = ~aclk;
  pixel_to_gray_conv dut (
    .aclk(aclk), .areset(areset), .mode_i(mode_i),
    .s_axis_pix_tdata(s_tdata), .s_axis_pix_tuser(s_tuser), .s_axis_pix_tlast(s_tlast),
    .s_axis_pix_tvalid(s_tvalid), .s_axis_pix_tready(s_tready),
    .m_axis_gray_tdata(m_tdata), .m_axis_gray_tuser(m_tuser), .m_axis_gray_tlast(m_tlast),
    .m_axis_gray_tvalid(m_tvalid), .m_axis_gray_tready(m_tready), .frame_mode_o(frame_mode)
  );
  function automatic void expect_beat(input logic [95:0] d, input logic u, input logic l, input logic [1:0] m);
    logic [31:0] g;
    if (u) mdl_mode = (m == 2'd3) ? 2'd0 : m;
    for (int p = 0; p < 4; p++) begin
      int gg = int'(d[24*p +: 8]);
      int bb = int'(d[24*p+8 +: 8]);
      int rr = int'(d[24*p+16 +: 8]);
      int yy = int'(d[16*p+8 +: 8]);
      g[8*p +: 8] = mdl_mode == 2'd1 ? 8'((77*rr + 150*gg + 29*bb + RND) >> 8)
                  : mdl_mode == 2'd2 ? 8'(gg) : 8'(yy);
    end
    q.push_back('{g, u, l});
  endfunction
  // call aligned to 1 time unit after a rising edge; returns 1 unit after the accepting edge
  task automatic send(input logic [95:0] d, input logic u, input logic l, input logic [1:0] m, input bit rnd);
    int c = 0;
    while (rnd && $urandom_range(0, 1) == 1) begin @(posedge aclk); #1; end
    s_tdata = d; s_tuser = u; s_tlast = l; mode_i = m; s_tvalid = 1;
    do begin @(negedge aclk); c++; end while (!s_tready && c < 500);
    if (s_tready) expect_beat(d, u, l, m);
    else begin errors++; $display("FAIL send_timeout: tready got %b want 1", s_tready); end
    @(posedge aclk); #1;
    s_tvalid = 0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge aclk);
    checks++;
    if ({m_tvalid, m_tdata, m_tuser, m_tlast, s_tready, frame_mode} !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h u=%b l=%b rdy=%b fm=%0d want all 0", m_tvalid, m_tdata, m_tuser, m_tlast, s_tready, frame_mode);
    end
    @(posedge aclk); #1 areset = 0;
    @(negedge aclk);
    checks++;
    if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", s_tready); end
    @(posedge aclk); #1;
  endtask
  task automatic test_yuv;
    m_tready = 1;
    send({32'h0, 8'h40, 8'h80, 8'h30, 8'h80, 8'h20, 8'h80, 8'h10, 8'h80}, 1, 1, 2'd0, 0);
    void'(q.pop_front());
    @(negedge aclk);
    checks++;
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL yuv_latency1: tvalid got %b want 0", m_tvalid); end
    @(negedge aclk);
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h40302010 || m_tuser !== 1'b1 || m_tlast !== 1'b1 || frame_mode !== 2'd0) begin
      errors++;
      $display("FAIL yuv_latency2: got v=%b d=%h u=%b l=%b fm=%0d want v=1 d=40302010 u=1 l=1 fm=0", m_tvalid, m_tdata, m_tuser, m_tlast, frame_mode);
    end
    @(posedge aclk); #1;
  endtask
  task automatic test_mode_switch;
    logic [1:0] mi [4] = '{2'd1, 2'd1, 2'd2, 2'd2};
    logic [1:0] fm [4] = '{2'd0, 2'd1, 2'd1, 2'd1};
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      int c = 0;
      send({$urandom, $urandom, $urandom}, i == 1, i == 3, mi[i], 0);
      checks++;
      if (frame_mode !== fm[i]) begin errors++; $display("FAIL mode_latch beat%0d: got %0d want %0d", i, frame_mode, fm[i]); end
      e = q.pop_front();
      do begin @(negedge aclk); c++; end while (!m_tvalid && c < 5);
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== e.d || m_tuser !== e.u || m_tlast !== e.l) begin
        errors++;
        $display("FAIL mode_switch beat%0d: got v=%b d=%h u=%b l=%b want d=%h u=%b l=%b", i, m_tvalid, m_tdata, m_tuser, m_tlast, e.d, e.u, e.l);
      end
      @(posedge aclk); #1;
    end
  endtask
  task automatic test_rgb;
    logic [95:0] dv [3];
    logic [1:0] mi [3] = '{2'd1, 2'd2, 2'd3};
    logic [1:0] fm [3] = '{2'd1, 2'd2, 2'd0};
    dv[0] = {24'h000000, 24'hFFFFFF, 24'h0000FF, 24'hFF0000};
    dv[1] = {$urandom, $urandom, $urandom};
    dv[2] = {$urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      int c = 0;
      send(dv[i], 1, 1, mi[i], 0);
      e = q.pop_front();
      checks++;
      if (frame_mode !== fm[i]) begin errors++; $display("FAIL rgb_frame_mode beat%0d: got %0d want %0d", i, frame_mode, fm[i]); end
      do begin @(negedge aclk); c++; end while (!m_tvalid && c < 5);
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== e.d) begin
        errors++;
        $display("FAIL rgb_model beat%0d: got v=%b d=%h want %h", i, m_tvalid, m_tdata, e.d);
      end
      if (i == 0) begin
        checks++;
        if (m_tdata !== {8'd0, 8'd255, 8'd149, RED_GRAY}) begin
          errors++;
          $display("FAIL rgb_const: got %h want %h", m_tdata, {8'd0, 8'd255, 8'd149, RED_GRAY});
        end
      end
      @(posedge aclk); #1;
    end
  endtask
  task automatic test_random;
    int got = 0;
    logic stall = 0;
    logic [33:0] prev = '0;
    fork
      for (int i = 0; i < 1000; i++) begin
        logic [95:0] d;
        for (int k = 0; k < 12; k++) d[8*k +: 8] = 8'(i*12 + k);
        send(d, i % 16 == 0, i % 16 == 15, 2'($urandom_range(0, 3)), 1);
      end
      begin
        for (int c = 0; c < 20000 && got < 1000; c++) begin
          @(posedge aclk); #1 m_tready = 1'($urandom_range(0, 1));
          @(negedge aclk);
          if (stall) begin
            checks++;
            if (m_tvalid !== 1'b1 || {m_tdata, m_tuser, m_tlast} !== prev) begin
              errors++;
              $display("FAIL stall_stable: got v=%b %h want v=1 %h", m_tvalid, {m_tdata, m_tuser, m_tlast}, prev);
            end
          end
          if (m_tvalid && m_tready) begin
            exp_t e = q.size() > 0 ? q.pop_front() : '0;
            got++;
            checks++;
            if ({m_tdata, m_tuser, m_tlast} !== {e.d, e.u, e.l}) begin
              errors++;
              $display("FAIL random_beat%0d: got %h want %h", got, {m_tdata, m_tuser, m_tlast}, {e.d, e.u, e.l});
            end
          end
          stall = m_tvalid && !m_tready;
          prev = {m_tdata, m_tuser, m_tlast};
        end
        if (got < 1000) begin errors++; $display("FAIL random_timeout: got %0d beats want 1000", got); end
      end
    join
    @(posedge aclk); #1 m_tready = 1;
  endtask
  task automatic test_stall;
    m_tready = 0;
    send({$urandom, $urandom, $urandom}, 1, 0, 2'd1, 0);
    send({$urandom, $urandom, $urandom}, 0, 0, 2'd2, 0);
    fork
      for (int i = 0; i < 4; i++) send({$urandom, $urandom, $urandom}, 0, i == 3, 2'd0, 0);
      begin
        for (int c = 0; c < 5; c++) begin
          @(negedge aclk);
          checks++;
          if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== q[0].d) begin
            errors++;
            $display("FAIL stall_full cyc%0d: got rdy=%b v=%b d=%h want rdy=0 v=1 d=%h", c, s_tready, m_tvalid, m_tdata, q[0].d);
          end
        end
        @(posedge aclk); #1 m_tready = 1;
        for (int i = 0; i < 6; i++) begin
          exp_t e;
          @(negedge aclk);
          e = q.size() > 0 ? q.pop_front() : '0;
          checks++;
          if (m_tvalid !== 1'b1 || {m_tdata, m_tuser, m_tlast} !== {e.d, e.u, e.l}) begin
            errors++;
            $display("FAIL stall_release beat%0d: got v=%b %h want v=1 %h", i, m_tvalid, {m_tdata, m_tuser, m_tlast}, {e.d, e.u, e.l});
          end
        end
      end
    join
    @(posedge aclk); #1;
  endtask
  task automatic test_async_reset;
    m_tready = 0;
    send({$urandom, $urandom, $urandom}, 1, 0, 2'd1, 0);
    send({$urandom, $urandom, $urandom}, 0, 0, 2'd1, 0);
    checks++;
    if (frame_mode !== 2'd1) begin errors++; $display("FAIL areset_pre_mode: got %0d want 1", frame_mode); end
    #2 areset = 1;
    #1;
    checks++;
    if ({m_tvalid, m_tdata, m_tuser, m_tlast, s_tready, frame_mode} !== '0) begin
      errors++;
      $display("FAIL areset_async: got v=%b d=%h u=%b l=%b rdy=%b fm=%0d want all 0", m_tvalid, m_tdata, m_tuser, m_tlast, s_tready, frame_mode);
    end
    repeat (2) begin
      @(negedge aclk);
      checks++;
      if (s_tready !== 1'b0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL areset_hold: got rdy=%b v=%b want 0 0", s_tready, m_tvalid); end
    end
    @(posedge aclk); #1 areset = 0;
    m_tready = 1;
    q.delete();
    mdl_mode = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk);
      checks++;
      if (m_tvalid !== 1'b0) begin errors++; $display("FAIL areset_stale cyc%0d: tvalid got %b want 0", c, m_tvalid); end
    end
    checks++;
    if (frame_mode !== 2'd0 || s_tready !== 1'b1) begin
      errors++;
      $display("FAIL areset_after: got fm=%0d rdy=%b want fm=0 rdy=1", frame_mode, s_tready);
    end
    @(posedge aclk); #1;
  endtask
  initial begin
    areset = 1; mode_i = 0; s_tdata = '0; s_tuser = 0; s_tlast = 0; s_tvalid = 0; m_tready = 1; mdl_mode = 0;
    test_reset;
    test_yuv;
    test_mode_switch;
    test_rgb;
    test_random;
    test_stall;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
